// File: rtl/memctrl_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
package memctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Request size encoding on iLen (2 and 3 both mean a word).
    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_4B = 2'd2;

    // addr[17:16] value that selects the IO window.
    localparam logic [1:0] IO_BASE_HI_DEFAULT = 2'b11;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_1B:  len_bytes = 3'd1;
            LEN_2B:  len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: fixed priority (MODE=0, lowest index wins) or
// round-robin (MODE=1, first requester after the last winner, wrapping).
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int MODE      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_PORTS-1:0] grant_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d, idx;
    logic             found;

    // Scan requesters in preference order and pick the first one set.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (MODE == 0) idx = PTR_W'(k);
            else           idx = PTR_W'((int'(ptr_q) + 1 + k) % NUM_PORTS);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = idx;
            end
        end
    end

    // Pointer remembers the last winner; reset value makes port 0 first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ptr_q <= PTR_W'(NUM_PORTS - 1);
        else if (advance_i) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port arbiter onto a byte-wide, one-cycle-latency RAM. Loads and
// stores of 1/2/4 bytes are serialised into byte beats; IO-space stores
// stall while the IO buffer is full.
// Build option: define MEMCTRL_SIGNEXT_EN to enable sign-extending loads.
//
// state | meaning
// IDLE  | no transfer; arbitrate, latch the winner's request
// READ  | drive n read addresses, collect bytes, assemble result
// WRITE | drive n write beats, hold a beat while IO buffer is full
module mem_arbiter
    import memctrl_pkg::*;
#(
    parameter int         NUM_PORTS  = 2,
    parameter int         ADDR_W     = 32,
    parameter int         ARB_MODE   = 1,
    parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rdy,
    input  logic                          iIO_buffer_full,
    input  logic [7:0]                    iMEM_dt,
    output logic                          oMEM_rw,
    output logic [ADDR_W-1:0]             oMEM_addr,
    output logic [7:0]                    oMEM_dt,
    input  logic [NUM_PORTS-1:0]          iReq,
    input  logic [NUM_PORTS-1:0]          iWe,
    input  logic [2*NUM_PORTS-1:0]        iLen,
    input  logic [NUM_PORTS-1:0]          iSigned,
    input  logic [ADDR_W*NUM_PORTS-1:0]   iAddr,
    input  logic [32*NUM_PORTS-1:0]       iWdata,
    output logic [NUM_PORTS-1:0]          oGrant,
    output logic [NUM_PORTS-1:0]          oDone,
    output logic [31:0]                   oRdata
);

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [2:0]             len_q, len_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   we_q, we_d;
    logic [3:0][7:0]        wdata_q, wdata_d;
    logic [3:0][7:0]        rbuf_q, rbuf_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   done_q, done_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [NUM_PORTS-1:0]   arb_grant;
    logic                   arb_advance;
    logic [ADDR_W-1:0]      sel_addr;
    logic [1:0]             sel_len;
    logic                   sel_we;
    logic [31:0]            sel_wdata;
    logic                   sel_signed;
    logic                   io_stall;
    logic [3:0][7:0]        raw;
    logic [1:0]             lane;

`ifdef MEMCTRL_SIGNEXT_EN
    logic signed_q, signed_d;
`else
    logic unused_signed;
    assign unused_signed = ^iSigned ^ sel_signed;
`endif

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .MODE      (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (iReq),
        .advance_i (arb_advance),
        .grant_o   (arb_grant)
    );

    // Mux the winning port's request fields.
    always_comb begin
        sel_addr   = '0;
        sel_len    = '0;
        sel_we     = 1'b0;
        sel_wdata  = '0;
        sel_signed = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_grant[i]) begin
                sel_addr   = iAddr[i*ADDR_W +: ADDR_W];
                sel_len    = iLen[2*i +: 2];
                sel_we     = iWe[i];
                sel_wdata  = iWdata[32*i +: 32];
`ifdef MEMCTRL_SIGNEXT_EN
                sel_signed = iSigned[i];
`endif
            end
        end
    end

    // Stall decision uses the latched base address of the store.
    assign io_stall    = (state_q == WRITE) && (addr_q[17:16] == IO_BASE_HI) && iIO_buffer_full;
    assign arb_advance = rdy && (state_q == IDLE) && (|iReq);

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        grant_d = grant_q;
        done_d  = '0;
        rdata_d = rdata_q;
        raw     = rbuf_q;
        lane    = cnt_q[1:0] - 2'd1;
`ifdef MEMCTRL_SIGNEXT_EN
        signed_d = signed_q;
`endif
        case (state_q)
            IDLE: begin
                if (|iReq) begin
                    grant_d = arb_grant;
                    addr_d  = sel_addr;
                    len_d   = len_bytes(sel_len);
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    rbuf_d  = '0;
                    cnt_d   = 3'd0;
                    state_d = sel_we ? WRITE : READ;
`ifdef MEMCTRL_SIGNEXT_EN
                    signed_d = sel_signed;
`endif
                end
            end
            READ: begin
                // Byte k-1 arrives while the counter reads k.
                if (cnt_q != 3'd0) raw[lane] = iMEM_dt;
                rbuf_d = raw;
                if (cnt_q == len_q) begin
                    case (len_q)
                        3'd1:    rdata_d = {24'h0, raw[0]};
                        3'd2:    rdata_d = {16'h0, raw[1], raw[0]};
                        default: rdata_d = raw;
                    endcase
`ifdef MEMCTRL_SIGNEXT_EN
                    if (signed_q) begin
                        case (len_q)
                            3'd1:    rdata_d = {{24{raw[0][7]}}, raw[0]};
                            3'd2:    rdata_d = {{16{raw[1][7]}}, raw[1], raw[0]};
                            default: rdata_d = raw;
                        endcase
                    end
`endif
                    done_d  = grant_q;
                    grant_d = '0;
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WRITE: begin
                if (!io_stall) begin
                    if (cnt_q == len_q - 3'd1) begin
                        done_d  = grant_q;
                        grant_d = '0;
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
`ifdef MEMCTRL_SIGNEXT_EN
            signed_q <= 1'b0;
`endif
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
`ifdef MEMCTRL_SIGNEXT_EN
            signed_q <= signed_d;
`endif
        end
    end

    // RAM bus: addresses only during active beats, zero otherwise.
    always_comb begin
        oMEM_rw   = 1'b0;
        oMEM_addr = '0;
        oMEM_dt   = 8'h00;
        if (state_q == WRITE) begin
            oMEM_rw   = rdy && !io_stall;
            oMEM_addr = addr_q + ADDR_W'(cnt_q);
            oMEM_dt   = wdata_q[cnt_q[1:0]];
        end else if ((state_q == READ) && (cnt_q < len_q)) begin
            oMEM_addr = addr_q + ADDR_W'(cnt_q);
        end
    end

    assign oGrant = grant_q;
    assign oDone  = done_q;
    assign oRdata = rdata_q;

    // we_q mirrors the state encoding but is kept for debug visibility.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus corner-case sequences.
module tb_mem_arbiter;

    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic              iIO_buffer_full;
    logic [7:0]        ram_dt;
    logic              oMEM_rw;
    logic [31:0]       oMEM_addr;
    logic [7:0]        oMEM_dt;
    logic [NP-1:0]     iReq, iWe, iSigned;
    logic [2*NP-1:0]   iLen;
    logic [32*NP-1:0]  iAddr, iWdata;
    logic [NP-1:0]     oGrant, oDone;
    logic [31:0]       oRdata;

    logic              fx_rw;
    logic [31:0]       fx_addr;
    logic [7:0]        fx_dt;
    logic [NP-1:0]     fx_grant, fx_done;
    logic [31:0]       fx_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .ARB_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .iIO_buffer_full(iIO_buffer_full),
        .iMEM_dt(ram_dt), .oMEM_rw(oMEM_rw), .oMEM_addr(oMEM_addr), .oMEM_dt(oMEM_dt),
        .iReq(iReq), .iWe(iWe), .iLen(iLen), .iSigned(iSigned), .iAddr(iAddr),
        .iWdata(iWdata), .oGrant(oGrant), .oDone(oDone), .oRdata(oRdata)
    );

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .ARB_MODE(0)) dut_fix (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .iIO_buffer_full(iIO_buffer_full),
        .iMEM_dt(ram_dt), .oMEM_rw(fx_rw), .oMEM_addr(fx_addr), .oMEM_dt(fx_dt),
        .iReq(iReq), .iWe(iWe), .iLen(iLen), .iSigned(iSigned), .iAddr(iAddr),
        .iWdata(iWdata), .oGrant(fx_grant), .oDone(fx_done), .oRdata(fx_rdata)
    );

    // RAM model: 4 KiB mirrored, one-cycle read latency.
    logic [7:0] mem [0:4095];
    logic       mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int a = 0; a < 4096; a++) mem[a] <= 8'h00;
            mem[12'h100] <= 8'h78; mem[12'h101] <= 8'h56;
            mem[12'h102] <= 8'h34; mem[12'h103] <= 8'h12;
            mem[12'h040] <= 8'h80;
            mem[12'h050] <= 8'h34; mem[12'h051] <= 8'h92;
            mem[12'hFFF] <= 8'h11; mem[12'h000] <= 8'h22;
            mem_init_done <= 1'b1;
        end else if (oMEM_rw) begin
            mem[oMEM_addr[11:0]] <= oMEM_dt;
        end
        ram_dt <= mem[oMEM_addr[11:0]];
    end

    // Log of write beats as {addr, data}.
    logic [39:0] wlog [$];
    always @(negedge clk) if (oMEM_rw) wlog.push_back({oMEM_addr, oMEM_dt});

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [1:0]  len;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        io_full;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    // Issue one request from a negedge and wait (bounded) for its oDone.
    task automatic run_vec(input vec_t v);
        int   lat;
        logic done;
        int   n;
        wlog.delete();
        iReq[v.port]            = 1'b1;
        iWe[v.port]             = v.we;
        iLen[2*v.port +: 2]     = v.len;
        iSigned[v.port]         = v.sgn;
        iAddr[32*v.port +: 32]  = v.addr;
        iWdata[32*v.port +: 32] = v.wdata;
        iIO_buffer_full         = v.io_full;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat == 1) chk("grant_onehot", 64'(oGrant), 64'(1 << v.port));
            if (oDone[v.port]) done = 1'b1;
        end
        iReq[v.port]    = 1'b0;
        iIO_buffer_full = 1'b0;
        chk("latency", 64'(lat), 64'(v.exp_lat));
        if (done) begin
            if (v.we) begin
                n = nbytes(v.len);
                chk("wr_beats", 64'(wlog.size()), 64'(n));
                for (int i = 0; i < n && i < wlog.size(); i++)
                    chk("wr_beat", 64'(wlog[i]), 64'({v.addr + 32'(i), v.wdata[8*i +: 8]}));
            end else begin
                chk("rdata", 64'(oRdata), 64'(v.exp_rdata));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sx80, sx9234;
        logic [1:0]  rr_s [4];
        logic [1:0]  fx_s [4];
        logic [1:0]  prr, pfx;
        int          nrr, nfx, k, stalls, done_seen;
        logic        done;

`ifdef MEMCTRL_SIGNEXT_EN
        sx80   = 32'hFFFF_FF80;
        sx9234 = 32'hFFFF_9234;
`else
        sx80   = 32'h0000_0080;
        sx9234 = 32'h0000_9234;
`endif
        //         port we len  sgn addr           wdata          io  exp_rdata      lat
        vecs[0]  = '{1, 0, 2'd2, 0, 32'h0000_0100, 32'h0,         0, 32'h1234_5678, 6};
        vecs[1]  = '{0, 1, 2'd0, 0, 32'h0000_0020, 32'h0000_00AB, 0, 32'h0,         2};
        vecs[2]  = '{0, 0, 2'd0, 0, 32'h0000_0020, 32'h0,         0, 32'h0000_00AB, 3};
        vecs[3]  = '{1, 1, 2'd1, 0, 32'h0000_0060, 32'h1234_BEEF, 0, 32'h0,         3};
        vecs[4]  = '{0, 0, 2'd3, 0, 32'h0000_0060, 32'h0,         0, 32'h0000_BEEF, 6};
        vecs[5]  = '{1, 0, 2'd1, 1, 32'h0000_0050, 32'h0,         0, sx9234,        4};
        vecs[6]  = '{0, 0, 2'd0, 1, 32'h0000_0040, 32'h0,         0, sx80,          3};
        vecs[7]  = '{0, 0, 2'd0, 0, 32'h0000_0040, 32'h0,         0, 32'h0000_0080, 3};
        vecs[8]  = '{1, 0, 2'd1, 0, 32'hFFFF_FFFF, 32'h0,         0, 32'h0000_2211, 4};
        vecs[9]  = '{0, 1, 2'd2, 0, 32'h0000_0200, 32'hDDCC_BBAA, 0, 32'h0,         5};
        vecs[10] = '{1, 0, 2'd0, 0, 32'h0003_0000, 32'h0,         1, 32'h0000_0022, 3};
        vecs[11] = '{0, 1, 2'd0, 0, 32'h0001_0000, 32'h0000_005A, 1, 32'h0,         2};

        rst_n = 1'b0; rdy = 1'b1; iIO_buffer_full = 1'b0;
        iReq = '0; iWe = '0; iLen = '0; iSigned = '0; iAddr = '0; iWdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(oGrant), 64'd0);
        chk("rst_done",  64'(oDone),  64'd0);
        chk("rst_rdata", 64'(oRdata), 64'd0);
        chk("rst_bus",   64'({oMEM_rw, oMEM_addr, oMEM_dt}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 12; v++) run_vec(vecs[v]);

        // IO store stalled for 3 cycles after its first beat.
        wlog.delete();
        iReq[0] = 1'b1; iWe[0] = 1'b1; iLen[1:0] = 2'd2;
        iAddr[31:0] = 32'h0003_0000; iWdata[31:0] = 32'h4433_2211;
        @(negedge clk);
        chk("io_beat0", 64'({oMEM_rw, oMEM_addr, oMEM_dt}), 64'({1'b1, 32'h0003_0000, 8'h11}));
        @(posedge clk); #1 iIO_buffer_full = 1'b1;
        stalls = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!oMEM_rw && oMEM_addr == 32'h0003_0001) stalls++;
            if (c < 2) @(posedge clk);
        end
        chk("io_stall_cycles", 64'(stalls), 64'd3);
        @(posedge clk); #1 iIO_buffer_full = 1'b0;
        k = 0; done = 1'b0;
        while (!done && k < 10) begin
            @(negedge clk); k++;
            if (oDone[0]) done = 1'b1;
            else @(posedge clk);
        end
        iReq[0] = 1'b0;
        chk("io_resume_lat", 64'(k), 64'd4);
        chk("io_beats", 64'(wlog.size()), 64'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("io_beat", 64'(wlog[i]), 64'({32'h0003_0000 + 32'(i), 8'(8'h11 * (i + 1))}));

        // rdy low freezes a store beat.
        @(negedge clk);
        wlog.delete();
        iReq[0] = 1'b1; iWe[0] = 1'b1; iLen[1:0] = 2'd0;
        iAddr[31:0] = 32'h0000_0070; iWdata[31:0] = 32'h0000_00C3;
        @(posedge clk); #1 rdy = 1'b0;
        @(negedge clk);
        chk("frz_rw0", 64'({oMEM_rw, oGrant}), 64'({1'b0, 2'b01}));
        @(posedge clk);
        @(negedge clk);
        chk("frz_rw1", 64'({oMEM_rw, oGrant}), 64'({1'b0, 2'b01}));
        @(posedge clk); #1 rdy = 1'b1;
        @(negedge clk);
        chk("frz_beat", 64'({oMEM_rw, oMEM_addr, oMEM_dt}), 64'({1'b1, 32'h0000_0070, 8'hC3}));
        @(negedge clk);
        chk("frz_done", 64'(oDone), 64'd1);
        iReq[0] = 1'b0;
        chk("frz_writes", 64'(wlog.size()), 64'd1);

        // Reset during the 3rd beat of a word read.
        @(negedge clk);
        iReq[1] = 1'b1; iWe[1] = 1'b0; iLen[3:2] = 2'd2; iAddr[63:32] = 32'h0000_0100;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_mid_addr", 64'(oMEM_addr), 64'h102);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 64'({oMEM_rw, oMEM_addr, oMEM_dt, oGrant, oDone}), 64'd0);
        chk("rst_mid_rdata", 64'(oRdata), 64'd0);
        iReq = '0;
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (oDone != '0) done_seen++;
        end
        chk("rst_no_done", 64'(done_seen), 64'd0);
        run_vec(vecs[0]);

        // Continuous requests from both ports: RR alternates, fixed keeps port 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        iWe = '0; iLen = '0; iSigned = '0;
        iAddr = {32'h0000_0100, 32'h0000_0040};
        iReq = 2'b11;
        nrr = 0; nfx = 0; prr = '0; pfx = '0;
        for (int c = 0; c < 60 && (nrr < 4 || nfx < 4); c++) begin
            @(negedge clk);
            if (oGrant != '0 && prr == '0 && nrr < 4) begin rr_s[nrr] = oGrant; nrr++; end
            if (fx_grant != '0 && pfx == '0 && nfx < 4) begin fx_s[nfx] = fx_grant; nfx++; end
            prr = oGrant;
            pfx = fx_grant;
        end
        iReq = '0;
        chk("rr_grant_count", 64'(nrr), 64'd4);
        chk("fx_grant_count", 64'(nfx), 64'd4);
        for (int i = 0; i < nrr; i++) chk("rr_order", 64'(rr_s[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        for (int i = 0; i < nfx; i++) chk("fx_order", 64'(fx_s[i]), 64'd1);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
